// File: rtl/pipe4_core_param.sv
// Parametrised 4-stage (IF/ID/EX/WB) in-order core with run/halt control and a retire trace port.
// Optional EX->ID operand bypass is enabled by defining FORWARDING_EN; otherwise RAW hazards stall one cycle.
module pipe4_core_param #(
   parameter int DW     = 8,
   parameter int NREGS  = 16,
   parameter int IDEPTH = 16,
   localparam int RA    = $clog2(NREGS),
   localparam int PW    = $clog2(IDEPTH),
   localparam int IW    = 4 + 3*RA
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          imem_we,
   input  logic [PW-1:0] imem_waddr,
   input  logic [IW-1:0] imem_wdata,
   input  logic          dmem_we,
   input  logic [RA-1:0] dmem_waddr,
   input  logic [DW-1:0] dmem_wdata,
   input  logic [RA-1:0] dbg_raddr,
   output logic [DW-1:0] dbg_rdata,
   output logic [PW-1:0] pc,
   output logic          busy,
   output logic          halted,
   output logic          retire_valid,
   output logic [RA-1:0] retire_rd,
   output logic [DW-1:0] retire_data
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_LOAD = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_HALT = 4'hF;

   function automatic logic op_writes(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

   function automatic logic op_reads(input logic [3:0] op);
      return op_writes(op) && (op != OP_LOAD);
   endfunction

   logic [IW-1:0] imem [IDEPTH];
   logic [DW-1:0] dmem [NREGS];
   logic [DW-1:0] regs [NREGS];

   state_t        state, state_next;
   logic [PW-1:0] pc_q;
   logic          launch, fetch_en, stall;

   logic [IW-1:0] if_id;
   logic          ex_wr;
   logic [3:0]    ex_op;
   logic [RA-1:0] ex_rd, ex_addr;
   logic [DW-1:0] ex_a, ex_b, ex_result;
   logic          wb_wr;
   logic [RA-1:0] wb_rd;
   logic [DW-1:0] wb_data;

   logic [IW-1:0] fetch;
   logic          fetch_halt;
   logic [3:0]    id_op;
   logic [RA-1:0] id_rd, id_rs1, id_rs2;
   logic [DW-1:0] id_a, id_b;

   assign fetch      = imem[pc_q];
   assign fetch_halt = fetch[IW-1 -: 4] == OP_HALT;
   assign id_op      = if_id[IW-1 -: 4];
   assign id_rd      = if_id[3*RA-1 -: RA];
   assign id_rs1     = if_id[2*RA-1 -: RA];
   assign id_rs2     = if_id[RA-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // DRAIN ends once nothing that writes is left in ID or EX; WB retires on the same edge.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, HALTED: if (start) state_next = RUN;
         RUN:          if (fetch_halt) state_next = DRAIN;
         DRAIN:        if (!op_writes(id_op) && !ex_wr) state_next = HALTED;
         default:      state_next = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == RUN) || (state == DRAIN);
      halted   = (state == HALTED);
      launch   = ((state == IDLE) || (state == HALTED)) && start;
      fetch_en = (state == RUN) && !fetch_halt && !stall;
   end

`ifdef FORWARDING_EN
   assign stall = 1'b0;
`else
   assign stall = op_reads(id_op) && ex_wr && ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
`endif

   // Operand read: write-first against WB, and with bypass the newer EX result wins.
   always_comb begin
      id_a = regs[id_rs1];
      id_b = regs[id_rs2];
      if (wb_wr && (wb_rd == id_rs1)) id_a = wb_data;
      if (wb_wr && (wb_rd == id_rs2)) id_b = wb_data;
`ifdef FORWARDING_EN
      if (ex_wr && (ex_rd == id_rs1)) id_a = ex_result;
      if (ex_wr && (ex_rd == id_rs2)) id_b = ex_result;
`endif
   end

   always_comb begin
      ex_result = '0;
      case (ex_op)
         OP_ADD:  ex_result = ex_a + ex_b;
         OP_SUB:  ex_result = ex_a - ex_b;
         OP_LOAD: ex_result = dmem[ex_addr];
         OP_AND:  ex_result = ex_a & ex_b;
         OP_OR:   ex_result = ex_a | ex_b;
         OP_XOR:  ex_result = ex_a ^ ex_b;
         default: ex_result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= '0;
         if_id   <= '0;
         ex_wr   <= 1'b0;
         ex_op   <= '0;
         ex_rd   <= '0;
         ex_addr <= '0;
         ex_a    <= '0;
         ex_b    <= '0;
         wb_wr   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else begin
         if (launch)        pc_q <= '0;
         else if (fetch_en) pc_q <= pc_q + 1'b1;
         if (!stall) begin
            if_id   <= fetch_en ? fetch : '0;
            ex_wr   <= op_writes(id_op);
            ex_op   <= id_op;
            ex_rd   <= id_rd;
            ex_addr <= id_rs2;
            ex_a    <= id_a;
            ex_b    <= id_b;
         end else begin
            ex_wr   <= 1'b0;
            ex_op   <= '0;
         end
         wb_wr   <= ex_wr;
         wb_rd   <= ex_rd;
         wb_data <= ex_result;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_wr) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // Host-loaded memories keep their contents across reset.
   always_ff @(posedge clk) begin
      if (imem_we && !busy) imem[imem_waddr] <= imem_wdata;
      if (dmem_we && !busy) dmem[dmem_waddr] <= dmem_wdata;
   end

   assign pc           = pc_q;
   assign dbg_rdata    = regs[dbg_raddr];
   assign retire_valid = wb_wr;
   assign retire_rd    = wb_wr ? wb_rd : '0;
   assign retire_data  = wb_wr ? wb_data : '0;

endmodule

// File: tb/tb_pipe4_core_param.sv
// Scoreboard bench for pipe4_core_param: expected retirements are queued by the stimulus
// and compared by a monitor on each retire; control/timing checks are directed.
module tb_pipe4_core_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        imem_we;
   logic [3:0]  imem_waddr;
   logic [15:0] imem_wdata;
   logic        dmem_we;
   logic [3:0]  dmem_waddr;
   logic [7:0]  dmem_wdata;
   logic [3:0]  dbg_raddr;
   logic [7:0]  dbg_rdata;
   logic [3:0]  pc;
   logic        busy, halted, retire_valid;
   logic [3:0]  retire_rd;
   logic [7:0]  retire_data;

   typedef struct {
      logic [3:0] rd;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

`ifdef FORWARDING_EN
   localparam int HALT_CYCLES = 6;
`else
   localparam int HALT_CYCLES = 7;
`endif

   pipe4_core_param dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc),
      .busy(busy), .halted(halted), .retire_valid(retire_valid),
      .retire_rd(retire_rd), .retire_data(retire_data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
      return {op, rd, rs1, rs2};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expectRetire(input logic [3:0] rd, input logic [7:0] data);
      exp_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: every retirement must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && retire_valid) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_retire", 32'(retire_rd), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("retire_rd", 32'(retire_rd), 32'(e.rd));
            checkOutput("retire_data", 32'(retire_data), 32'(e.data));
         end
      end
   end

   task automatic writeImem(input logic [3:0] a, input logic [15:0] d);
      imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
      @(posedge clk); #1;
      imem_we = 1'b0;
   endtask

   task automatic writeDmem(input logic [3:0] a, input logic [7:0] d);
      dmem_we = 1'b1; dmem_waddr = a; dmem_wdata = d;
      @(posedge clk); #1;
      dmem_we = 1'b0;
   endtask

   task automatic applyStimulus();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitHalted(output int cyc);
      cyc = 0;
      while (!halted && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!halted) checkOutput("halt_timeout", 32'(cyc), 32'd0);
   endtask

   task automatic checkReg(input logic [3:0] idx, input logic [7:0] exp);
      dbg_raddr = idx;
      #1;
      checkOutput($sformatf("reg_R%0d", idx), 32'(dbg_rdata), 32'(exp));
   endtask

   task automatic loadProg2();
      writeImem(4'd0, enc(4'h3, 4'd4, 4'd0, 4'd4));
      writeImem(4'd1, enc(4'h2, 4'd5, 4'd0, 4'd4));
      writeImem(4'd2, enc(4'h6, 4'd6, 4'd5, 4'd5));
      writeImem(4'd3, enc(4'h4, 4'd7, 4'd1, 4'd5));
      writeImem(4'd4, enc(4'h5, 4'd8, 4'd2, 4'd4));
      writeImem(4'd5, enc(4'h1, 4'd9, 4'd5, 4'd4));
      writeImem(4'd6, enc(4'h7, 4'd10, 4'd5, 4'd5));
      writeImem(4'd7, enc(4'hF, 4'd0, 4'd0, 4'd0));
   endtask

   task automatic expectProg2(input logic [7:0] r1, input logic [7:0] r2);
      expectRetire(4'd4, 8'h03);
      expectRetire(4'd5, 8'hFD);
      expectRetire(4'd6, 8'h00);
      expectRetire(4'd7, r1 & 8'hFD);
      expectRetire(4'd8, r2 | 8'h03);
      expectRetire(4'd9, 8'h00);
   endtask

   initial begin
      int cyc;
      bit wrapped;
      reset = 1'b1; start = 1'b0;
      imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      dmem_we = 1'b0; dmem_waddr = '0; dmem_wdata = '0;
      dbg_raddr = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_pc", 32'(pc), 32'd0);
      checkOutput("rst_retire_valid", 32'(retire_valid), 32'd0);
      checkOutput("rst_retire_data", 32'(retire_data), 32'd0);
      for (int i = 0; i < 16; i++) checkReg(4'(i), 8'h00);
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] program 1: LOAD, LOAD, dependent ADD, HALT");
      writeDmem(4'd2, 8'd99);
      writeDmem(4'd3, 8'd5);
      writeDmem(4'd4, 8'd3);
      writeImem(4'd0, enc(4'h3, 4'd2, 4'd0, 4'd2));
      writeImem(4'd1, enc(4'h3, 4'd3, 4'd0, 4'd3));
      writeImem(4'd2, enc(4'h1, 4'd1, 4'd2, 4'd3));
      writeImem(4'd3, enc(4'hF, 4'd0, 4'd0, 4'd0));
      expectRetire(4'd2, 8'd99);
      expectRetire(4'd3, 8'd5);
      expectRetire(4'd1, 8'h68);
      applyStimulus();
      waitHalted(cyc);
      checkOutput("halt_latency", 32'(cyc), 32'(HALT_CYCLES));
      checkOutput("halt_pc", 32'(pc), 32'd3);
      checkOutput("halt_busy", 32'(busy), 32'd0);
      checkReg(4'd1, 8'h68);

      $display("[TB] program 2: SUB wrap, XOR, AND, OR, ADD wrap, undefined op; busy writes ignored");
      loadProg2();
      expectProg2(8'h68, 8'h63);
      applyStimulus();
      checkOutput("start_pc0", 32'(pc), 32'd0);
      writeImem(4'd0, enc(4'hF, 4'd0, 4'd0, 4'd0));
      writeDmem(4'd4, 8'h77);
      applyStimulus();
      waitHalted(cyc);
      checkOutput("prog2_pc", 32'(pc), 32'd7);
      checkReg(4'd5, 8'hFD);
      checkReg(4'd10, 8'h00);
      checkReg(4'd1, 8'h68);
      expectProg2(8'h68, 8'h63);
      applyStimulus();
      checkOutput("restart_pc0", 32'(pc), 32'd0);
      waitHalted(cyc);
      checkOutput("prog2_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] reset while busy, then rerun");
      applyStimulus();
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_pc", 32'(pc), 32'd0);
      checkOutput("abort_retire_valid", 32'(retire_valid), 32'd0);
      for (int i = 0; i < 16; i++) checkReg(4'(i), 8'h00);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      expectProg2(8'h00, 8'h00);
      applyStimulus();
      waitHalted(cyc);
      checkOutput("rerun_pc", 32'(pc), 32'd7);
      checkOutput("rerun_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] all-NOP program wraps pc");
      for (int i = 0; i < 16; i++) writeImem(4'(i), 16'h0000);
      applyStimulus();
      wrapped = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         checkOutput("nop_pc", 32'(pc), 32'(k % 16));
         checkOutput("nop_busy", 32'(busy), 32'd1);
         checkOutput("nop_retire", 32'(retire_valid), 32'd0);
         if (k == 16) wrapped = (pc == 4'd0);
      end
      checkOutput("nop_wrapped", 32'(wrapped), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
